alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//   Parametrised, two-stage pipelined ALU with a valid/ready stream interface,
//   full C/Z/N/V flags and a stored carry flag (CF) for multi-word ADC/SBC chains.
//   Successor to the 8-bit combinational ALU. Sits between operand fetch and
//   writeback in the datapath. Backpressure is honoured and full throughput
//   is kept (1 op/cycle).
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>=2)
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous reset, active-high
//   in_valid    in   1      operation presented
//   in_ready    out  1      ALU accepts operation this cycle
//   in_a        in   WIDTH  operand A
//   in_b        in   WIDTH  operand B
//   in_op       in   3      000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 AND, 101 OR, 110 XOR, 111 BIC(A&~B)
//   in_cin      in   1      external carry/borrow-in for ADC/SBC
//   in_use_cf   in   1      1: ADC/SBC use stored CF instead of in_cin
//   flag_clr    in   1      synchronous clear of CF
//   out_valid   out  1      result valid
//   out_ready   in   1      downstream accepts result
//   out_result  out  WIDTH  result
//   out_carry   out  1      carry (add) / borrow (sub); 0 for logic ops
//   out_zero    out  1      result == 0
//   out_neg     out  1      result[WIDTH-1]
//   out_ovf     out  1      signed overflow; 0 for logic ops
//   cf          out  1      stored carry flag
// BEHAVIOUR
//   - Reset (async, rst=1): S1/S2 valid=0; out_result=0; out_carry=0;
//     out_zero=0; out_neg=0; out_ovf=0; cf=0; out_valid=0.
//   - S1: captures a, b, op, cin, use_cf on in_valid&in_ready.
//     S2: computes at the S1->S2 transfer and registers the result and flags.
//   - Latency: accepted at edge N -> out_valid at edge N+1 (visible the cycle after acceptance).
//   - adv2 = ~s2_valid | out_ready. adv1 = s1_valid & adv2.
//     in_ready = ~s1_valid | adv2 (combinational; no comb path from in_valid).
//   - S2 holds all outputs stable while out_valid & ~out_ready. Dropping out_ready never loses or duplicates ops.
//   - Carry select: c = in_use_cf ? cf : in_cin. cf is read at the S1->S2 transfer,
//     so back-to-back ADC/SBC chain correctly with no bubble.
//   - Arithmetic at WIDTH+1 bits: {C,R} = A+B (ADD), A+B+c (ADC), A-B (SUB), A-B-c (SBC).
//     For SUB/SBC, C = borrow (1 when A < B+c unsigned).
//   - V: add ops: A[msb]==B[msb] && R[msb]!=A[msb];
//        sub ops: A[msb]!=B[msb] && R[msb]!=A[msb].
//   - Logic ops: C=0, V=0; cf unchanged.
//   - Z = (R==0) and N = R[msb] for every op.
//   - cf update: on the S1->S2 transfer of an arithmetic op, cf <= C.
//     Otherwise flag_clr=1 -> cf <= 0.
//     If both occur in the same cycle, the arithmetic op wins.
//   - Both stages full with out_ready=0: in_ready=0, state frozen, cf frozen.
//   - rst mid-operation discards all in-flight ops immediately; no partial outputs.
// TESTING
//   1. WIDTH=8, ADD 0xFF+0x01, out_ready=1 -> out_result=0x00, C=1, Z=1, N=0, V=0, cf=1, one cycle after accept.
//   2. 16-bit add as two 8-bit ops: ADD 0x34+0xDD then ADC(use_cf) 0x12+0x00, back-to-back
//      -> 0x11 (C=1), then 0x13 (C=0); cf=0.
//   3. SUB 0x10-0x20 -> 0xF0, C=1, N=1, V=0; SUB 0x80-0x01 -> 0x7F, V=1, C=0.
//   4. Backpressure: stream 4 ADDs with out_ready held 0 for 3 cycles
//      -> in_ready=0 after 2 accepts; all 4 results emerge in order, none duplicated.
//   5. cf=1, flag_clr with AND transferring same cycle -> cf=0.
//      flag_clr with ADD 0xFF+0x01 transferring -> cf=1.
//   6. Assert rst with both stages full -> out_valid=0 and cf=0 immediately (no clock needed);
//      first op after release returns correctly. Repeat 1-3 at WIDTH=16 with scaled values.

Source files
------------

// File: rtl/alu_pipe.sv
`default_nettype none
// =============================================================================
// Module  : alu_pipe
// Purpose : Two-stage valid/ready pipelined ALU with C/Z/N/V flags and a
//           stored carry flag (cf) for chaining multi-word ADC/SBC sequences.
// Rev     : 1.0  initial release
// =============================================================================
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_cin,
  input  logic             in_use_cf,
  input  logic             flag_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic             cf
);

  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  logic             adv1, adv2, accept;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             cin_q, cin_d, use_cf_q, use_cf_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d, zero_q, zero_d;
  logic             neg_q, neg_d, ovf_q, ovf_d;
  logic             cf_q, cf_d;

  logic [WIDTH:0]   ext_a, ext_b, ext_c, sum;
  logic [WIDTH-1:0] logic_r, res;
  logic             is_arith, is_sub, carry_in, c_res, v_res;

  always_comb begin : handshake
    adv2     = ~s2_valid_q | out_ready;
    adv1     = s1_valid_q & adv2;
    in_ready = ~s1_valid_q | adv2;
    accept   = in_valid & in_ready;
  end

  // cf is sampled here, at the S1->S2 transfer, so chained ADC/SBC need no bubble.
  always_comb begin : compute
    ext_a    = {1'b0, a_q};
    ext_b    = {1'b0, b_q};
    is_arith = ~op_q[2];
    is_sub   = op_q[1];
    carry_in = op_q[0] & (use_cf_q ? cf_q : cin_q);
    ext_c    = {{WIDTH{1'b0}}, carry_in};
    sum      = is_sub ? (ext_a - ext_b - ext_c) : (ext_a + ext_b + ext_c);
    case (op_q)
      OP_AND:  logic_r = a_q & b_q;
      OP_OR:   logic_r = a_q | b_q;
      OP_XOR:  logic_r = a_q ^ b_q;
      default: logic_r = a_q & ~b_q;
    endcase
    res   = is_arith ? sum[WIDTH-1:0] : logic_r;
    c_res = is_arith & sum[WIDTH];
    v_res = is_arith & ((a_q[WIDTH-1] ^ b_q[WIDTH-1]) == is_sub)
                     & (res[WIDTH-1] ^ a_q[WIDTH-1]);
  end

  always_comb begin : next_state
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cin_d      = cin_q;
    use_cf_d   = use_cf_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      a_d        = in_a;
      b_d        = in_b;
      op_d       = in_op;
      cin_d      = in_cin;
      use_cf_d   = in_use_cf;
    end else if (adv1) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    if (adv1) begin
      result_d = res;
      carry_d  = c_res;
      zero_d   = (res == '0);
      neg_d    = res[WIDTH-1];
      ovf_d    = v_res;
    end

    // An arithmetic transfer takes priority over a simultaneous clear.
    cf_d = cf_q;
    if (adv1 && is_arith) begin
      cf_d = c_res;
    end else if (flag_clr) begin
      cf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cin_q      <= 1'b0;
      use_cf_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      cf_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cin_q      <= cin_d;
      use_cf_q   <= use_cf_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
      cf_q       <= cf_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = result_q;
  assign out_carry  = carry_q;
  assign out_zero   = zero_q;
  assign out_neg    = neg_q;
  assign out_ovf    = ovf_q;
  assign cf         = cf_q;

endmodule
`default_nettype wire
